// File: rtl/reimu_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reimu_life_ctrl
//  Purpose  : Player life controller for the shooter core. Tracks remaining
//             lives, runs a post-hit invincibility (i-frame) window with
//             sprite blinking, handles extra-life pickups with a saturating
//             ceiling, emits a one-cycle hit event and a sticky game-over.
//  Ports    :
//    clk_22     in   1       game clock, rising edge
//    rst_n      in   1       synchronous active-low reset
//    gamestart  in   1       synchronous re-initialisation (same as reset)
//    shot       in   1       player hit this cycle (level)
//    extend     in   1       extra-life pickup this cycle (level)
//    life       out  LIFE_W  remaining lives
//    reimuE     out  1       sprite / hitbox enable (blinks during i-frames)
//    invinc     out  1       high while in the i-frame window
//    hit_pulse  out  1       one-cycle pulse per accepted hit
//    game_over  out  1       high once lives reach 0, until re-init
//  Revision : 1.0  initial release
// ============================================================================
module reimu_life_ctrl #(
  parameter int LIFE_W     = 3,
  parameter int INIT_LIFE  = 3,
  parameter int MAX_LIFE   = 7,
  parameter int TIMER_W    = 6,
  parameter int IFRAME_LEN = 32,
  parameter int BLINK_BIT  = 2
) (
  input  logic              clk_22,
  input  logic              rst_n,
  input  logic              gamestart,
  input  logic              shot,
  input  logic              extend,
  output logic [LIFE_W-1:0] life,
  output logic              reimuE,
  output logic              invinc,
  output logic              hit_pulse,
  output logic              game_over
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVINC = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  localparam logic [LIFE_W:0]    c_MAX_LIFE   = (LIFE_W+1)'(MAX_LIFE);
  localparam logic [LIFE_W:0]    c_ONE        = (LIFE_W+1)'(1);
  localparam logic [LIFE_W-1:0]  c_INIT_LIFE  = LIFE_W'(INIT_LIFE);
  localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(IFRAME_LEN-1);
  localparam logic [TIMER_W-1:0] c_TIMER_ONE  = TIMER_W'(1);

  state_t              r_state, w_state_nxt;
  logic [TIMER_W-1:0]  r_timer, w_timer_nxt;
  logic [LIFE_W-1:0]   r_life,  w_life_nxt;
  logic                r_hit_pulse, w_hit_nxt;
  logic                r_game_over;

  // Life arithmetic carried one bit wider so +1 at the ceiling and -1 at
  // zero can be detected and clamped instead of wrapping.
  logic [LIFE_W:0]     w_life_ext;
  logic [LIFE_W:0]     w_life_inc;
  logic [LIFE_W:0]     w_hit_sum;
  logic [LIFE_W:0]     w_life_hit;
  logic [LIFE_W-1:0]   w_life_inc_sat;
  logic [LIFE_W-1:0]   w_life_hit_sat;

  assign w_life_ext = {1'b0, r_life};
  assign w_life_inc = w_life_ext + c_ONE;
  // A hit removes one life; a pickup in the same cycle gives it back.
  assign w_hit_sum  = w_life_ext + {{LIFE_W{1'b0}}, extend};
  assign w_life_hit = (w_hit_sum == '0) ? '0 : (w_hit_sum - c_ONE);

  assign w_life_inc_sat = (w_life_inc > c_MAX_LIFE) ? c_MAX_LIFE[LIFE_W-1:0]
                                                    : w_life_inc[LIFE_W-1:0];
  assign w_life_hit_sat = (w_life_hit > c_MAX_LIFE) ? c_MAX_LIFE[LIFE_W-1:0]
                                                    : w_life_hit[LIFE_W-1:0];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_life_nxt  = r_life;
    w_hit_nxt   = 1'b0;
    case (r_state)
      ST_ALIVE: begin
        if (shot) begin
          w_life_nxt  = w_life_hit_sat;
          w_hit_nxt   = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = (w_life_hit_sat == '0) ? ST_DEAD : ST_INVINC;
        end else if (extend) begin
          w_life_nxt = w_life_inc_sat;
        end
      end
      ST_INVINC: begin
        // Hits are ignored here; pickups still count.
        if (r_timer == c_TIMER_LAST) begin
          w_state_nxt = ST_ALIVE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + c_TIMER_ONE;
        end
        if (extend) begin
          w_life_nxt = w_life_inc_sat;
        end
      end
      ST_DEAD: begin
        w_life_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_ALIVE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_22) begin
    if (!rst_n || gamestart) begin
      r_state     <= ST_ALIVE;
      r_timer     <= '0;
      r_life      <= c_INIT_LIFE;
      r_hit_pulse <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_life      <= w_life_nxt;
      r_hit_pulse <= w_hit_nxt;
      r_game_over <= (w_state_nxt == ST_DEAD);
    end
  end

  // Output decode (registers only, no path from shot/extend)
  always_comb begin
    reimuE = 1'b0;
    case (r_state)
      ST_ALIVE:  reimuE = 1'b1;
      ST_INVINC: reimuE = r_timer[BLINK_BIT];
      default:   reimuE = 1'b0;
    endcase
  end

  assign life      = r_life;
  assign invinc    = (r_state == ST_INVINC);
  assign hit_pulse = r_hit_pulse;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_reimu_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reimu_life_ctrl
//  Purpose  : Self-checking bench for reimu_life_ctrl. A behavioural model
//             predicts every cycle's outputs into a scoreboard queue; a
//             vector table and hand sequences add constant checkpoints.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reimu_life_ctrl;

  logic       clk_22 = 1'b0;
  logic       rst_n = 1'b0;
  logic       gamestart = 1'b0;
  logic       shot = 1'b0;
  logic       extend = 1'b0;
  logic [2:0] life;
  logic       reimuE, invinc, hit_pulse, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk_22 = ~clk_22;

  reimu_life_ctrl #(
    .LIFE_W(3), .INIT_LIFE(3), .MAX_LIFE(7),
    .TIMER_W(6), .IFRAME_LEN(32), .BLINK_BIT(2)
  ) dut (
    .clk_22(clk_22), .rst_n(rst_n), .gamestart(gamestart),
    .shot(shot), .extend(extend), .life(life), .reimuE(reimuE),
    .invinc(invinc), .hit_pulse(hit_pulse), .game_over(game_over)
  );

  // Behavioural model: st 0=alive 1=invincible 2=dead
  int m_life = 3, m_st = 0, m_t = 0, m_hit = 0;

  typedef struct {
    int life; int inv; int hit; int go; int re;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic rn; logic gs; logic sh; logic ex; int n;
    int life; int inv; int hit; int go; int re;
  } vec_t;

  int hits_seen;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic gs, input logic sh, input logic ex);
    exp_t e;
    int l;
    if (!rn || gs) begin
      m_life = 3; m_st = 0; m_t = 0; m_hit = 0;
    end else if (m_st == 0) begin
      m_hit = 0;
      if (sh) begin
        l = m_life - 1 + (ex ? 1 : 0);
        if (l < 0) l = 0;
        if (l > 7) l = 7;
        m_life = l; m_hit = 1; m_t = 0;
        m_st = (l == 0) ? 2 : 1;
      end else if (ex) begin
        m_life = (m_life >= 7) ? 7 : m_life + 1;
      end
    end else if (m_st == 1) begin
      m_hit = 0;
      if (m_t == 31) begin m_st = 0; m_t = 0; end
      else m_t = m_t + 1;
      if (ex) m_life = (m_life >= 7) ? 7 : m_life + 1;
    end else begin
      m_hit = 0; m_life = 0;
    end
    e.life = m_life;
    e.inv  = (m_st == 1) ? 1 : 0;
    e.hit  = m_hit;
    e.go   = (m_st == 2) ? 1 : 0;
    e.re   = (m_st == 0) ? 1 : ((m_st == 1) ? ((m_t >> 2) & 1) : 0);
    sbq.push_back(e);
  endtask

  // One clock: drive on negedge, push prediction, compare #1 after posedge.
  task automatic step(input logic rn, input logic gs, input logic sh, input logic ex);
    exp_t e;
    @(negedge clk_22);
    rst_n = rn; gamestart = gs; shot = sh; extend = ex;
    model_step(rn, gs, sh, ex);
    @(posedge clk_22);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("sb_life",      int'(life),      e.life);
      chk("sb_invinc",    int'(invinc),    e.inv);
      chk("sb_hit_pulse", int'(hit_pulse), e.hit);
      chk("sb_game_over", int'(game_over), e.go);
      chk("sb_reimuE",    int'(reimuE),    e.re);
    end
    if (hit_pulse) hits_seen++;
  endtask

  task automatic steps(input int n, input logic rn, input logic gs, input logic sh, input logic ex);
    for (int k = 0; k < n; k++) step(rn, gs, sh, ex);
  endtask

  task automatic chk_out(input string tag, input int l, input int inv, input int hit,
                         input int go, input int re);
    chk({tag, "_life"},      int'(life),      l);
    chk({tag, "_invinc"},    int'(invinc),    inv);
    chk({tag, "_hit_pulse"}, int'(hit_pulse), hit);
    chk({tag, "_game_over"}, int'(game_over), go);
    chk({tag, "_reimuE"},    int'(reimuE),    re);
  endtask

  vec_t tbl [11];

  initial begin
    //             rn    gs    sh    ex    n   life inv hit go re
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2,  3,   0,  0,  0, 1}; // reset
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1,  3,   0,  0,  0, 1}; // idle
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0,  1,  2,   1,  1,  0, 0}; // hit
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  3,  2,   1,  0,  0, 0}; // timer 3
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1,  2,   1,  0,  0, 1}; // timer 4 blink on
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 27,  2,   1,  0,  0, 1}; // timer 31
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1,  2,   0,  0,  0, 1}; // back to alive
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1,  6,  7,   0,  0,  0, 1}; // extend saturates
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0,  1,  6,   1,  1,  0, 0}; // hit from max
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1,  1,  7,   1,  0,  0, 0}; // extend in i-frames
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0,  1,  3,   0,  0,  0, 1}; // gamestart mid-INVINC

    hits_seen = 0;
    for (int i = 0; i < 11; i++) begin
      steps(tbl[i].n, tbl[i].rn, tbl[i].gs, tbl[i].sh, tbl[i].ex);
      chk_out($sformatf("vec%0d", i), tbl[i].life, tbl[i].inv, tbl[i].hit,
              tbl[i].go, tbl[i].re);
    end

    // Held shot from 3 lives: hits 33 cycles apart, then sticky game over.
    hits_seen = 0;
    steps(200, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("held_hits", hits_seen, 3);
    chk_out("held_end", 0, 0, 0, 1, 0);
    steps(3, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("dead_extend", 0, 0, 0, 1, 0);

    // gamestart recovers from DEAD
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("gs_dead", 3, 0, 0, 0, 1);

    // Bring life down to 1, then shot+extend together keeps it at 1
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(32, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("life1", 1, 0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk_out("shot_ext_l1", 1, 1, 1, 0, 0);
    hits_seen = 0;
    steps(5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("invinc_shot_hits", hits_seen, 0);
    chk_out("invinc_shot", 1, 1, 0, 0, 1);

    // gamestart mid-INVINC, then a fresh hit restarts the timer at 0
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("gs_invinc", 3, 0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("restart_t3", 2, 1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("restart_t4", 2, 1, 0, 0, 1);

    // rst_n wins over gamestart and suppresses a coincident hit
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk_out("rst_prio", 3, 0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reimu_life_ctrl.md
# reimu_life_ctrl

Parametrised player life controller for the shooter core, the next generation of the fixed 3-life player block. It tracks remaining lives and runs an invincibility (i-frame) window with sprite blinking after each hit. It also adds extra-life pickups, a saturating life ceiling, a one-cycle hit event and a sticky game-over flag. It sits between the collision detector (hit input), the item logic (extend input) and the sprite renderer / HUD / game-flow FSM (outputs).

## Interface
Parameters:
- LIFE_W, 3: width of the life counter.
- INIT_LIFE, 3: lives loaded on reset or gamestart; 1 ≤ INIT_LIFE ≤ MAX_LIFE.
- MAX_LIFE, 7: ceiling for extra lives; ≤ 2^LIFE_W − 1.
- TIMER_W, 6: i-frame timer width.
- IFRAME_LEN, 32: i-frame window length in cycles; 1 ≤ IFRAME_LEN ≤ 2^TIMER_W.
- BLINK_BIT, 2: timer bit driving the blink; < TIMER_W.

Ports:
- clk_22  in  1  system game clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- gamestart  in  1  synchronous re-initialisation, same effect as reset.
- shot  in  1  player hit this cycle (level, sampled each cycle).
- extend  in  1  extra-life pickup this cycle (level, sampled each cycle).
- life  out  LIFE_W  remaining lives.
- reimuE  out  1  player sprite/hitbox enable.
- invinc  out  1  high while in the i-frame window.
- hit_pulse  out  1  one-cycle pulse for each accepted hit.
- game_over  out  1  sticky, high once lives reach 0.

## Operation
- **States:** ALIVE, INVINC, DEAD. A TIMER_W-bit timer is used only in INVINC.
- **Init:** when rst_n=0 or gamestart=1:
  - life=INIT_LIFE, state=ALIVE, timer=0.
  - hit_pulse=0, game_over=0.
  - rst_n has priority; both do the same thing.
- **ALIVE:**
  - shot=1 is accepted: life_next = life − 1 + (extend ? 1 : 0), saturated to [0, MAX_LIFE]. hit_pulse=1 next cycle.
  - If life_next==0, go to DEAD. Otherwise go to INVINC with timer=0.
  - extend alone: life saturating +1, capped at MAX_LIFE.
- **INVINC:**
  - timer increments each cycle.
  - When timer==IFRAME_LEN−1, go to ALIVE next cycle and clear timer. INVINC therefore lasts exactly IFRAME_LEN cycles.
  - shot is ignored (no decrement, no hit_pulse).
  - extend applies (saturating +1).
- **DEAD:**
  - shot and extend are ignored; life holds 0.
  - Leave only on rst_n=0 or gamestart=1.
- **Outputs:**
  - reimuE = 1 in ALIVE; timer[BLINK_BIT] in INVINC; 0 in DEAD.
  - invinc = (state==INVINC).
  - game_over = (state==DEAD), registered.
- **Arithmetic:**
  - Compute life ± 1 at LIFE_W+1 bits, then clamp.
  - life never wraps below 0 and never exceeds MAX_LIFE.

## Timing
- **Reset values:** life=INIT_LIFE, reimuE=1, invinc=0, hit_pulse=0, game_over=0. All are visible the cycle after the reset edge.
- **Registered outputs:** all outputs are registers or decodes of registers only. There is no combinational path from shot/extend to any output.
- **Hit latency:** shot sampled at edge N gives life, state and hit_pulse updated after edge N. At cycle N+1, reimuE=0 (timer=0 and BLINK_BIT is low at timer 0).
- **Blink pattern:** with BLINK_BIT=2, reimuE toggles every 4 cycles during INVINC. It returns to 1 on the first ALIVE cycle.
- **shot held high:** one hit per i-frame window. The next hit is accepted on the first ALIVE cycle, so a held shot gives hits spaced IFRAME_LEN+1 cycles apart.
- **gamestart / rst_n mid-INVINC or in DEAD:** immediate return to init values next cycle. The timer is cleared and any pending hit_pulse is suppressed.
- **Simultaneous shot+extend at life=1 in ALIVE:** life stays 1, enters INVINC, no game_over.

## Test plan
- **Reset:** rst_n=0 for 2 cycles, then 1 → life=3, reimuE=1, invinc=0, game_over=0.
- **Single hit:** shot for 1 cycle in ALIVE → life=2 and hit_pulse high for exactly 1 cycle. invinc stays high for 32 cycles. reimuE is 0,0,0,0,1,1,1,1… during the window and then 1.
- **Held shot:** shot held 200 cycles from life=3 → hits at cycles 0, 33 and 66. life goes 3→2→1→0. game_over rises with life=0; reimuE=0 and hit_pulse does not pulse again.
- **Extend saturation:** 6 extend pulses from life=3 → life=7 (MAX_LIFE) and no wrap. A further shot → life=6.
- **Simultaneous shot+extend at life=1:** life stays 1, INVINC entered, hit_pulse=1, game_over=0. A shot during INVINC → no change.
- **gamestart recovery:** gamestart in DEAD → life=3, game_over=0, reimuE=1. gamestart mid-INVINC → invinc=0 next cycle and the timer restarts at 0 on the next hit.
